// File: rtl/edram_pkg.sv
// Shared constants, slot phase numbering and operation types for the edram controller.
package edram_pkg;

    localparam int unsigned EDRAM_ROWS          = 32;
    localparam int unsigned EDRAM_WIDTH         = 325;
    localparam int unsigned EDRAM_REF_INTERVAL  = 16;
    localparam int unsigned EDRAM_REF_MAX_DEFER = 4;
    localparam int unsigned ADDR_W              = $clog2(EDRAM_ROWS);

    // Phase numbers within a 4-clk slot; PH_RDATA/PH_RSP/PH_DATA/PH_WB refer to slot N+1.
    localparam logic [1:0] PH_ISSUE = 2'd0;
    localparam logic [1:0] PH_RDATA = 2'd0;
    localparam logic [1:0] PH_RSP   = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;
    localparam logic [1:0] PH_WB    = 2'd3;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RD,
        OP_WR,
        OP_REF
    } op_e;

endpackage

// File: rtl/edram_ref_sched.sv
// Refresh scheduler: interval timer, pending/defer tracking and round-robin refresh row.
module edram_ref_sched
    import edram_pkg::*;
#(
    parameter int unsigned REF_INTERVAL  = EDRAM_REF_INTERVAL,
    parameter int unsigned REF_MAX_DEFER = EDRAM_REF_MAX_DEFER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              slot_tick,
    input  logic              client_win,
    input  logic              ref_issue,
    output logic              ref_pending,
    output logic              ref_force,
    output logic [ADDR_W-1:0] ref_row
);

    localparam int unsigned INT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int unsigned DEF_W = (REF_MAX_DEFER > 0) ? $clog2(REF_MAX_DEFER + 1) : 1;

    logic [INT_W-1:0]  int_cnt_q, int_cnt_d;
    logic [DEF_W-1:0]  defer_q, defer_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_cnt_q <= '0;
            defer_q   <= '0;
            pending_q <= 1'b0;
            row_q     <= '0;
        end else begin
            int_cnt_q <= int_cnt_d;
            defer_q   <= defer_d;
            pending_q <= pending_d;
            row_q     <= row_d;
        end
    end

    // An expiry while already pending is absorbed into the single pending flag.
    always_comb begin
        int_cnt_d = int_cnt_q;
        defer_d   = defer_q;
        pending_d = pending_q;
        row_d     = row_q;
        expire    = slot_tick && (int_cnt_q == INT_W'(REF_INTERVAL - 1));
        if (slot_tick) begin
            int_cnt_d = expire ? '0 : int_cnt_q + INT_W'(1);
        end
        if (ref_issue) begin
            pending_d = 1'b0;
            defer_d   = '0;
            row_d     = row_q + ADDR_W'(1);
        end else if (client_win && pending_q) begin
            defer_d = defer_q + DEF_W'(1);
        end
        if (expire) begin
            pending_d = 1'b1;
        end
    end

    assign ref_pending = pending_q;
    assign ref_force   = pending_q && (defer_q == DEF_W'(REF_MAX_DEFER));
    assign ref_row     = row_q;

endmodule

// File: rtl/edram_ctrl.sv
// edram controller: serialises client requests and refreshes into 4-clk slots,
// with a uniform writeback stage in the slot after each issue.
module edram_ctrl
    import edram_pkg::*;
#(
    parameter int unsigned WIDTH         = EDRAM_WIDTH,
    parameter int unsigned REF_INTERVAL  = EDRAM_REF_INTERVAL,
    parameter int unsigned REF_MAX_DEFER = EDRAM_REF_MAX_DEFER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              port_en,
    output logic              port_ref_plus2,
    output logic [ADDR_W-1:0] port_read_addr,
    input  logic [WIDTH-1:0]  port_read_data,
    output logic [ADDR_W-1:0] port_write_addr,
    output logic [WIDTH-1:0]  port_write_data,
    output logic              port_wen_plus3,
    output logic              port_data
);

    logic [1:0]        phase_q, phase_d;
    op_e               iss_op_q, iss_op_d, wb_op_q, wb_op_d;
    logic [ADDR_W-1:0] iss_row_q, iss_row_d, wb_row_q, wb_row_d;
    logic [WIDTH-1:0]  iss_data_q, iss_data_d, wb_data_q, wb_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic              wen_q, wen_d, pdata_q, pdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;

    logic              is_issue, cli_hazard, ref_hazard, cli_accept, ref_issue;
    logic              ref_pending, ref_force;
    logic [ADDR_W-1:0] ref_row;

    edram_ref_sched #(
        .REF_INTERVAL  (REF_INTERVAL),
        .REF_MAX_DEFER (REF_MAX_DEFER)
    ) u_ref_sched (
        .clk         (clk),
        .rst         (rst),
        .slot_tick   (phase_q == PH_ISSUE),
        .client_win  (cli_accept),
        .ref_issue   (ref_issue),
        .ref_pending (ref_pending),
        .ref_force   (ref_force),
        .ref_row     (ref_row)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q     <= '0;
            iss_op_q    <= OP_NONE;
            iss_row_q   <= '0;
            iss_data_q  <= '0;
            wb_op_q     <= OP_NONE;
            wb_row_q    <= '0;
            wb_data_q   <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wen_q       <= 1'b0;
            pdata_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            phase_q     <= phase_d;
            iss_op_q    <= iss_op_d;
            iss_row_q   <= iss_row_d;
            iss_data_q  <= iss_data_d;
            wb_op_q     <= wb_op_d;
            wb_row_q    <= wb_row_d;
            wb_data_q   <= wb_data_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wen_q       <= wen_d;
            pdata_q     <= pdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Phase-0 arbitration; a row still in writeback blocks whichever op would reuse it.
    always_comb begin
        is_issue   = rst && (phase_q == PH_ISSUE);
        cli_hazard = (wb_op_q != OP_NONE) && (wb_row_q == req_addr);
        ref_hazard = (wb_op_q != OP_NONE) && (wb_row_q == ref_row);
        req_ready  = is_issue && !ref_force && !cli_hazard;
        cli_accept = req_valid && req_ready;
        ref_issue  = is_issue && ref_pending && (ref_force || !req_valid) && !ref_hazard;
        port_en        = cli_accept && !req_we;
        port_ref_plus2 = ref_issue;
        if (ref_issue) begin
            port_read_addr = ref_row;
        end else if (port_en) begin
            port_read_addr = req_addr;
        end else begin
            port_read_addr = rd_addr_q;
        end
    end

    // Issue stage captures at phase 0 and hands over to writeback at the slot boundary.
    always_comb begin
        phase_d    = phase_q + 2'd1;
        iss_op_d   = iss_op_q;
        iss_row_d  = iss_row_q;
        iss_data_d = iss_data_q;
        wb_op_d    = wb_op_q;
        wb_row_d   = wb_row_q;
        wb_data_d  = wb_data_q;
        rd_addr_d  = port_read_addr;
        if (is_issue) begin
            iss_op_d = OP_NONE;
            if (ref_issue) begin
                iss_op_d  = OP_REF;
                iss_row_d = ref_row;
            end else if (cli_accept) begin
                iss_op_d   = req_we ? OP_WR : OP_RD;
                iss_row_d  = req_addr;
                iss_data_d = req_wdata;
            end
        end
        if (phase_q == PH_WB) begin
            wb_op_d   = iss_op_q;
            wb_row_d  = iss_row_q;
            wb_data_d = iss_data_q;
        end
    end

    // Writeback-slot outputs, registered one clk ahead of the phase they belong to.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rsp_data_d  = rsp_data_q;
        wen_d       = (phase_d == PH_WB) && (wb_op_q != OP_NONE);
        pdata_d     = (phase_d == PH_DATA) && (wb_op_q == OP_WR);
        rsp_valid_d = (phase_d == PH_RSP) && (wb_op_q == OP_RD);
        if ((phase_q == PH_WB) && (iss_op_q != OP_NONE)) begin
            wr_addr_d = iss_row_q;
        end
        if (pdata_d) begin
            wr_data_d = wb_data_q;
        end
        if ((phase_q == PH_RDATA) && (wb_op_q == OP_RD)) begin
            rsp_data_d = port_read_data;
        end
    end

    assign port_write_addr = wr_addr_q;
    assign port_write_data = wr_data_q;
    assign port_wen_plus3  = wen_q;
    assign port_data       = pdata_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;

endmodule

// File: tb/tb_edram_ctrl.sv
// Slot-level reference model and simple edram macro model driving edram_ctrl.
module tb_edram_ctrl;

    localparam int unsigned W             = 325;
    localparam int unsigned REF_INTERVAL  = 16;
    localparam int unsigned REF_MAX_DEFER = 4;

    typedef enum logic [1:0] {M_NONE, M_RD, M_WR, M_REF} mop_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_we = 1'b0;
    logic [4:0]   req_addr = '0;
    logic [W-1:0] req_wdata = '0;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         port_en, port_ref_plus2, port_wen_plus3, port_data;
    logic [4:0]   port_read_addr, port_write_addr;
    logic [W-1:0] port_read_data, port_write_data;

    edram_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .port_en         (port_en),
        .port_ref_plus2  (port_ref_plus2),
        .port_read_addr  (port_read_addr),
        .port_read_data  (port_read_data),
        .port_write_addr (port_write_addr),
        .port_write_data (port_write_data),
        .port_wen_plus3  (port_wen_plus3),
        .port_data       (port_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_val(input int r);
        logic [W-1:0] v = '0;
        for (int i = 0; i < 11; i++) v = (v << 32) | W'(32'(r * 32'h9E3779B1 + i));
        return v;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] v = '0;
        for (int i = 0; i < 11; i++) v = (v << 32) | W'($urandom());
        return v;
    endfunction

    // Macro model: rows start at init_val, loaded data is written on the wen strobe.
    logic [W-1:0] macro_mem [32];
    bit           mac_written [32];
    bit   [4:0]   mac_raddr;
    logic [W-1:0] mac_wbuf;
    bit           mac_wflag;

    assign port_read_data = mac_written[mac_raddr] ? macro_mem[mac_raddr] : init_val(int'(mac_raddr));

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_wflag <= 1'b0;
        end else begin
            if (port_en || port_ref_plus2) mac_raddr <= port_read_addr;
            if (port_data) begin
                mac_wbuf  <= port_write_data;
                mac_wflag <= 1'b1;
            end else if (port_wen_plus3) begin
                mac_wflag <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst && port_wen_plus3 && mac_wflag) begin
            macro_mem[port_write_addr]   <= mac_wbuf;
            mac_written[port_write_addr] <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference state, one update per slot.
    int           m_int, m_defer, m_ref_row, last_raddr, last_waddr, wb_row;
    bit           m_pend;
    mop_t         wb_op;
    logic [W-1:0] wb_data, wb_rdata;
    logic [W-1:0] m_mem [32];

    task automatic model_reset();
        m_int = 0; m_defer = 0; m_ref_row = 0; m_pend = 0;
        last_raddr = 0; last_waddr = 0; wb_op = M_NONE; wb_row = 0;
        wb_data = '0; wb_rdata = '0;
    endtask

    // Runs one slot; entered and left 1 time unit after the phase-0 rising edge.
    task automatic run_slot(input bit v, input bit we, input int a, input logic [W-1:0] d,
                            output bit acc);
        bit           frc, rdy, expire;
        mop_t         op;
        int           row, exp_raddr, exp_waddr;
        logic [W-1:0] rdat;
        req_valid = v; req_we = we; req_addr = 5'(a); req_wdata = d;
        frc = m_pend && (m_defer == REF_MAX_DEFER);
        rdy = !frc && !(wb_op != M_NONE && wb_row == a);
        op  = M_NONE;
        row = 0;
        if (m_pend && (frc || !v)) begin
            if (!(wb_op != M_NONE && wb_row == m_ref_row)) begin
                op = M_REF; row = m_ref_row;
            end
        end else if (v && rdy) begin
            op = we ? M_WR : M_RD; row = a;
        end
        acc       = (op == M_RD) || (op == M_WR);
        exp_raddr = (op == M_RD || op == M_REF) ? row : last_raddr;
        rdat      = m_mem[row];
        exp_waddr = (wb_op != M_NONE) ? wb_row : last_waddr;

        @(negedge clk);
        check_eq("req_ready", W'(req_ready), W'(rdy));
        check_eq("port_en", W'(port_en), W'(op == M_RD));
        check_eq("port_ref_plus2", W'(port_ref_plus2), W'(op == M_REF));
        check_eq("port_read_addr", W'(port_read_addr), W'(exp_raddr));
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        check_eq("rsp_valid", W'(rsp_valid), W'(wb_op == M_RD));
        if (wb_op == M_RD) check_eq("rsp_data", rsp_data, wb_rdata);
        check_eq("strobe_ph1", W'(port_en | port_ref_plus2 | port_wen_plus3), '0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("port_data", W'(port_data), W'(wb_op == M_WR));
        if (wb_op == M_WR) check_eq("port_write_data", port_write_data, wb_data);
        check_eq("port_write_addr_ph2", W'(port_write_addr), W'(exp_waddr));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("port_wen_plus3", W'(port_wen_plus3), W'(wb_op != M_NONE));
        check_eq("port_write_addr_ph3", W'(port_write_addr), W'(exp_waddr));
        check_eq("rsp_valid_ph3", W'(rsp_valid | port_data), '0);

        if (wb_op == M_WR) m_mem[wb_row] = wb_data;
        last_raddr = exp_raddr;
        last_waddr = exp_waddr;
        wb_op = op; wb_row = row; wb_data = d; wb_rdata = rdat;
        expire = (m_int == REF_INTERVAL - 1);
        m_int  = expire ? 0 : m_int + 1;
        if (op == M_REF) begin
            m_pend = 0; m_defer = 0; m_ref_row = (m_ref_row + 1) % 32;
        end else if (acc && m_pend) begin
            m_defer++;
        end
        if (expire) m_pend = 1;
        @(posedge clk); #1;
    endtask

    task automatic client_op(input bit we, input int a, input logic [W-1:0] d);
        bit acc = 0;
        for (int n = 0; n < 20 && !acc; n++) run_slot(1'b1, we, a, d, acc);
    endtask

    task automatic idle_slots(input int n);
        bit acc;
        for (int i = 0; i < n; i++) run_slot(1'b0, 1'b0, 0, '0, acc);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, W'({req_ready, rsp_valid, port_en, port_ref_plus2,
                                    port_wen_plus3, port_data}), '0);
        check_eq({tag, "_addr"}, W'({port_read_addr, port_write_addr}), '0);
        check_eq({tag, "_wdata"}, port_write_data, '0);
        check_eq({tag, "_rdata"}, rsp_data, '0);
    endtask

    task automatic reset_mid_writeback();
        logic [W-1:0] dd = rand_word();
        client_op(1'b1, 11, dd);
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("wb_port_data", W'(port_data), W'(wb_op == M_WR));
        check_eq("wb_port_wdata", port_write_data, dd);
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_hold_wen", W'(port_wen_plus3 | port_data | port_en), '0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        bit           acc, hv, hwe;
        int           ha;
        logic [W-1:0] hd, data_a;
        for (int r = 0; r < 32; r++) m_mem[r] = init_val(r);
        model_reset();

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Idle: refresh rows 0..31 then 0 again, one every 16 slots.
        idle_slots(16 * 33 + 1);

        // Write row 5, read 9, read 5 returns the written data.
        data_a = rand_word();
        client_op(1'b1, 5, data_a);
        client_op(1'b0, 9, '0);
        client_op(1'b0, 5, '0);
        idle_slots(2);

        // Same-row back-to-back reads, then read/write same row.
        client_op(1'b0, 7, '0);
        client_op(1'b0, 7, '0);
        idle_slots(1);
        client_op(1'b0, 3, '0);
        client_op(1'b1, 3, rand_word());
        client_op(1'b0, 3, '0);
        idle_slots(2);

        reset_mid_writeback();

        // Continuous reads across a refresh expiry: client wins until forced.
        for (int s = 0; s < 40; s++) run_slot(1'b1, 1'b0, (s * 3) % 32, '0, acc);

        // Random traffic on a few rows so hazards and refresh collisions occur.
        hv = 0; hwe = 0; ha = 0; hd = '0;
        for (int s = 0; s < 400; s++) begin
            if (!hv && $urandom_range(0, 9) < 7) begin
                hv  = 1;
                hwe = 1'($urandom_range(0, 1));
                ha  = $urandom_range(0, 7);
                hd  = rand_word();
            end
            run_slot(hv, hwe, ha, hd, acc);
            if (acc) hv = 0;
        end
        idle_slots(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/edram_ctrl.md
Name: edram_ctrl

Overview:
- Initiator/scheduler for the edram macro; the controller end of the macro's port protocol.
- Accepts single-row client read/write requests and serialises them into the macro's 4-clk slot protocol.
- Generates periodic round-robin refresh and drives the mandatory writeback after every destructive read, write or refresh.
- Sits between a cache/line-buffer client and one edram instance.

Parameters:
- ROWS, 32, row count; addresses are 5 bits and wrap 31->0.
- WIDTH, 325, row width in bits, ECC included.
- REF_INTERVAL, 16, slots between refresh requests.
- REF_MAX_DEFER, 4, slots a pending refresh may yield to client traffic before it is forced.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  request accepted this clk when req_valid&req_ready.
- req_we  in  1  1=write, 0=read.
- req_addr  in  5  row address.
- req_wdata  in  WIDTH  write data.
- rsp_valid  out  1  one-clk pulse, read data valid.
- rsp_data  out  WIDTH  read data.
- port_en  out  1  macro read strobe.
- port_ref_plus2  out  1  macro refresh-read strobe.
- port_read_addr  out  5  macro read/refresh row.
- port_read_data  in  WIDTH  macro read data.
- port_write_addr  out  5  macro writeback row.
- port_write_data  out  WIDTH  macro write data.
- port_wen_plus3  out  1  macro writeback strobe.
- port_data  out  1  load port_write_data into the macro write path.

Behaviour:
- Reset: all outputs 0, phase=0, ref_row=0, interval counter=0, defer counter=0, pipeline empty.
- Phase counter: 2 bits, counts 0..3 continuously. One slot = phases 0..3. Issue decisions are made only at phase 0.
- req_ready is 1 only at phase 0 when all of the following hold:
  - the slot is not taken by a refresh;
  - there is no same-row hazard;
  - otherwise it is combinationally 1 at phase 0.
- Issue slot N, phase 0:
  - client read: port_en=1, port_read_addr=req_addr.
  - refresh: port_ref_plus2=1, port_read_addr=ref_row.
  - client write: no macro read strobe; the write row and data are captured in the writeback stage.
  - All strobes are 1 clk wide.
- Writeback, slot N+1 (uniform for every op):
  - port_write_addr is held at the op row for the whole slot.
  - Write only: at phase 2, port_data=1 and port_write_data=captured wdata.
  - At phase 3: port_wen_plus3=1.
  - Exactly one writeback per slot, so there is no write-port conflict.
- Read response:
  - sample port_read_data at slot N+1 phase 0;
  - rsp_valid=1 with rsp_data at slot N+1 phase 1;
  - latency from acceptance is 5 clks.
- Refresh scheduling:
  - the interval counter increments once per slot;
  - at REF_INTERVAL-1 it sets ref_pending and wraps to 0.
  - With ref_pending, a phase-0 slot with no valid client request issues the refresh.
  - Otherwise the client wins and the defer counter increments.
  - When defer counter = REF_MAX_DEFER, the refresh is forced and req_ready=0.
  - Issuing a refresh clears pending and defer, and increments ref_row mod 32.
  - A new interval expiry while still pending is absorbed: it does not queue a second refresh.
- Same-row hazard: if the row in writeback (slot N+1) equals the candidate row for slot N+1, the slot idles.
  - Candidate row is req_addr or ref_row.
  - req_ready=0; refresh also waits; no strobes.
  - The op issues next slot.
- Idle slot: no strobes; port addresses hold their last values.
- Reset mid-operation: in-flight writeback is abandoned, no strobes are emitted afterwards, and the client must reissue.
- Simultaneous forced refresh and client request: refresh wins, client stalls exactly one slot unless a hazard applies.

Decomposition:
- Shared package edram_pkg holds:
  - EDRAM_ROWS, EDRAM_WIDTH, slot phase constants PH_ISSUE=0, PH_RDATA=0 (of N+1), PH_RSP=1, PH_DATA=2, PH_WB=3;
  - op-type enum {OP_NONE, OP_RD, OP_WR, OP_REF}.
- Sub-module edram_ref_sched holds the interval counter, pending flag, defer counter and ref_row; it outputs ref_pending, ref_force and ref_row.

Test Plan:
- Reset release, no requests, REF_INTERVAL=16 -> port_ref_plus2 pulses every 64 clks, port_read_addr 0,1,2,…,31,0; port_wen_plus3 at phase 3 of each following slot with matching port_write_addr.
- Write row 5 data A, then read row 9, then read row 5 -> port_data at phase 2 with A; rsp_data=A at 5 clks after the row-5 read acceptance.
- Read row 7 immediately followed by read row 7 -> one idle slot between them, second port_en 8 clks after first; two rsp pulses.
- Continuous client reads with refresh pending -> client wins 4 slots, then refresh forced with req_ready=0 for that slot; ref_row increments.
- Read row 3 and write row 3 back-to-back -> hazard stall; writeback order: row 3 read writeback, then write data at the following slot.
- Assert rst low at phase 2 of a writeback slot -> all outputs 0 immediately; after release, phase starts at 0 and ref_row=0.
